mem_access: RTL and testbench

//  Memory stage: consumes the EX/MEM register, runs one load/store per instruction on a

---
 rtl/mem_pkg.sv | 17 +
 rtl/load_align.sv | 26 ++
 rtl/mem_access.sv | 168 ++++++++++++++++
 tb/tb_mem_access.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding and byte-lane geometry.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_e;

  localparam int LANE_W = 8;
  localparam int LANES  = 4;

  localparam logic [LANES-1:0] BE_WORD  = 4'b1111;
  localparam logic [LANES-1:0] BE_BYTE0 = 4'b0001;

endpackage

// File: rtl/load_align.sv
// Byte-lane steering for the data-memory port: byte enables, store replication and
// zero-extended byte extraction from load data. Purely combinational.
module load_align
  import mem_pkg::*;
(
  input  logic                       word,
  input  logic [1:0]                 addr_lo,
  input  logic [LANES*LANE_W-1:0]    store_data,
  input  logic [LANES*LANE_W-1:0]    load_raw,
  output logic [LANES-1:0]           be,
  output logic [LANES*LANE_W-1:0]    wdata,
  output logic [LANES*LANE_W-1:0]    load_data
);

  always_comb begin
    be        = BE_WORD;
    wdata     = store_data;
    load_data = load_raw;
    if (!word) begin
      be        = BE_BYTE0 << addr_lo;
      wdata     = {LANES{store_data[LANE_W-1:0]}};
      load_data = {{(LANES*LANE_W-LANE_W){1'b0}}, load_raw[addr_lo*LANE_W +: LANE_W]};
    end
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: one load/store per instruction over a valid/ready data port, results to MEM/WB.
// Optional MEM_MISALIGN_EXC_EN turns misaligned word accesses into exceptions instead of requests.
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_memRead,
  input  logic              in_memWrite,
  input  logic              in_word,
  input  logic              in_memToReg,
  input  logic              in_regWrite,
  input  logic [ADDR_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_readData2,
  input  logic [4:0]        in_rd,
  input  logic              in_exception,
  input  logic [ADDR_W-1:0] in_faulty_address,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_req_write,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [3:0]        dmem_req_be,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic              stall_at_memory,
  output logic              wb_regWrite,
  output logic              wb_memToReg,
  output logic [4:0]        wb_rd,
  output logic [ADDR_W-1:0] wb_aluResult,
  output logic [DATA_W-1:0] wb_loadData,
  output logic              wb_exception,
  output logic [ADDR_W-1:0] wb_faulty_address,
  output logic [ADDR_W-1:0] wb_pc
);

  mem_state_e state, state_next;

  logic              cap_write;
  logic              cap_word;
  logic              cap_mem_to_reg;
  logic              cap_reg_write;
  logic [4:0]        cap_rd;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_store;
  logic [ADDR_W-1:0] cap_pc;

  logic              misalign;
  logic              mem_op;
  logic [DATA_W-1:0] load_data;

`ifdef MEM_MISALIGN_EXC_EN
  assign misalign = in_word & (in_memRead | in_memWrite) & ~in_exception
                  & (in_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign mem_op = (in_memRead | in_memWrite) & ~in_exception & ~misalign;

  load_align u_load_align (
    .word       (cap_word),
    .addr_lo    (cap_addr[1:0]),
    .store_data (cap_store),
    .load_raw   (dmem_rsp_rdata),
    .be         (dmem_req_be),
    .wdata      (dmem_req_wdata),
    .load_data  (load_data)
  );

  assign dmem_req_write = cap_write;
  assign dmem_req_addr  = {cap_addr[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next      = state;
    dmem_req_valid  = 1'b0;
    stall_at_memory = 1'b0;
    case (state)
      IDLE: if (mem_op) begin
        stall_at_memory = 1'b1;
        state_next      = REQ;
      end
      REQ: begin
        dmem_req_valid  = 1'b1;
        stall_at_memory = 1'b1;
        if (dmem_req_ready) state_next = WAIT;
      end
      WAIT: begin
        stall_at_memory = 1'b1;
        if (dmem_rsp_valid) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured fields stay frozen from IDLE through RESP so the request is stable while stalled.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cap_write      <= 1'b0;
      cap_word       <= 1'b0;
      cap_mem_to_reg <= 1'b0;
      cap_reg_write  <= 1'b0;
      cap_rd         <= '0;
      cap_addr       <= '0;
      cap_store      <= '0;
      cap_pc         <= '0;
    end else if (state == IDLE && mem_op) begin
      cap_write      <= in_memWrite;
      cap_word       <= in_word;
      cap_mem_to_reg <= in_memToReg;
      cap_reg_write  <= in_regWrite;
      cap_rd         <= in_rd;
      cap_addr       <= in_result;
      cap_store      <= in_readData2;
      cap_pc         <= in_pc;
    end
  end

  // wb_* defaults to a bubble every cycle; only a non-memory IDLE cycle or a response fills it.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_regWrite       <= 1'b0;
      wb_memToReg       <= 1'b0;
      wb_rd             <= '0;
      wb_aluResult      <= '0;
      wb_loadData       <= '0;
      wb_exception      <= 1'b0;
      wb_faulty_address <= '0;
      wb_pc             <= '0;
    end else begin
      wb_regWrite       <= 1'b0;
      wb_memToReg       <= 1'b0;
      wb_rd             <= '0;
      wb_aluResult      <= '0;
      wb_loadData       <= '0;
      wb_exception      <= 1'b0;
      wb_faulty_address <= '0;
      wb_pc             <= '0;
      if (state == IDLE && !mem_op) begin
        wb_regWrite       <= in_regWrite & ~in_exception & ~misalign;
        wb_memToReg       <= in_memToReg;
        wb_rd             <= in_rd;
        wb_aluResult      <= in_result;
        wb_exception      <= in_exception | misalign;
        wb_faulty_address <= misalign ? in_result : in_faulty_address;
        wb_pc             <= in_pc;
      end else if (state == WAIT && dmem_rsp_valid) begin
        wb_regWrite  <= cap_reg_write;
        wb_memToReg  <= cap_mem_to_reg;
        wb_rd        <= cap_rd;
        wb_aluResult <= cap_addr;
        wb_loadData  <= cap_write ? '0 : load_data;
        wb_pc        <= cap_pc;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, word/byte loads and stores, exceptions,
// misaligned word access (either build) and reset during an outstanding request.
module tb_mem_access;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_memRead, in_memWrite, in_word, in_memToReg, in_regWrite;
  logic [31:0] in_result, in_readData2;
  logic [4:0]  in_rd;
  logic        in_exception;
  logic [31:0] in_faulty_address, in_pc;
  logic        dmem_req_valid, dmem_req_ready, dmem_req_write;
  logic [31:0] dmem_req_addr;
  logic [3:0]  dmem_req_be;
  logic [31:0] dmem_req_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        stall_at_memory;
  logic        wb_regWrite, wb_memToReg;
  logic [4:0]  wb_rd;
  logic [31:0] wb_aluResult, wb_loadData;
  logic        wb_exception;
  logic [31:0] wb_faulty_address, wb_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_access dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .in_memRead        (in_memRead),
    .in_memWrite       (in_memWrite),
    .in_word           (in_word),
    .in_memToReg       (in_memToReg),
    .in_regWrite       (in_regWrite),
    .in_result         (in_result),
    .in_readData2      (in_readData2),
    .in_rd             (in_rd),
    .in_exception      (in_exception),
    .in_faulty_address (in_faulty_address),
    .in_pc             (in_pc),
    .dmem_req_valid    (dmem_req_valid),
    .dmem_req_ready    (dmem_req_ready),
    .dmem_req_write    (dmem_req_write),
    .dmem_req_addr     (dmem_req_addr),
    .dmem_req_be       (dmem_req_be),
    .dmem_req_wdata    (dmem_req_wdata),
    .dmem_rsp_valid    (dmem_rsp_valid),
    .dmem_rsp_rdata    (dmem_rsp_rdata),
    .stall_at_memory   (stall_at_memory),
    .wb_regWrite       (wb_regWrite),
    .wb_memToReg       (wb_memToReg),
    .wb_rd             (wb_rd),
    .wb_aluResult      (wb_aluResult),
    .wb_loadData       (wb_loadData),
    .wb_exception      (wb_exception),
    .wb_faulty_address (wb_faulty_address),
    .wb_pc             (wb_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    in_memRead = 0; in_memWrite = 0; in_word = 0; in_memToReg = 0; in_regWrite = 0;
    in_result = 0; in_readData2 = 0; in_rd = 0; in_exception = 0;
    in_faulty_address = 0; in_pc = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rsp_rdata = 0;
    tick(); tick();
    check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    check("rst_stall", 32'(stall_at_memory), 32'd0);
    check("rst_wb_regwrite", 32'(wb_regWrite), 32'd0);
    check("rst_wb_alu", wb_aluResult, 32'd0);

    // ALU op pass-through
    reset_n = 1;
    in_regWrite = 1; in_rd = 5; in_result = 32'h1234; in_pc = 32'h40;
    #1 check("alu_stall", 32'(stall_at_memory), 32'd0);
    tick();
    check("alu_wb_regwrite", 32'(wb_regWrite), 32'd1);
    check("alu_wb_rd", 32'(wb_rd), 32'd5);
    check("alu_wb_result", wb_aluResult, 32'h1234);
    check("alu_wb_pc", wb_pc, 32'h40);
    check("alu_wb_load", wb_loadData, 32'd0);

    // word load 0x100, response two cycles after acceptance
    clear_inputs();
    in_memRead = 1; in_word = 1; in_memToReg = 1; in_regWrite = 1; in_rd = 7;
    in_result = 32'h100; dmem_req_ready = 1;
    #1 check("wl_idle_stall", 32'(stall_at_memory), 32'd1);
    tick();
    check("wl_req_valid", 32'(dmem_req_valid), 32'd1);
    check("wl_req_addr", dmem_req_addr, 32'h100);
    check("wl_req_be", 32'(dmem_req_be), 32'hF);
    check("wl_req_write", 32'(dmem_req_write), 32'd0);
    check("wl_bubble", 32'(wb_regWrite), 32'd0);
    tick();
    dmem_req_ready = 0;
    check("wl_wait_valid", 32'(dmem_req_valid), 32'd0);
    check("wl_wait_stall", 32'(stall_at_memory), 32'd1);
    tick();
    check("wl_wait2_stall", 32'(stall_at_memory), 32'd1);
    dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hDEADBEEF;
    tick();
    dmem_rsp_valid = 0;
    check("wl_resp_stall", 32'(stall_at_memory), 32'd0);
    check("wl_resp_regwrite", 32'(wb_regWrite), 32'd1);
    check("wl_resp_load", wb_loadData, 32'hDEADBEEF);
    check("wl_resp_rd", 32'(wb_rd), 32'd7);
    check("wl_resp_memtoreg", 32'(wb_memToReg), 32'd1);
    clear_inputs();
    tick();
    check("wl_after_regwrite", 32'(wb_regWrite), 32'd0);

    // byte store 0x103, ready held low for two cycles
    in_memWrite = 1; in_word = 0; in_readData2 = 32'h123456AB; in_result = 32'h103;
    tick();
    check("bs_req_valid", 32'(dmem_req_valid), 32'd1);
    check("bs_req_write", 32'(dmem_req_write), 32'd1);
    check("bs_req_be", 32'(dmem_req_be), 32'h8);
    check("bs_req_wdata", dmem_req_wdata, 32'hABABABAB);
    check("bs_req_addr", dmem_req_addr, 32'h100);
    tick();
    check("bs_hold_valid", 32'(dmem_req_valid), 32'd1);
    check("bs_hold_be", 32'(dmem_req_be), 32'h8);
    dmem_req_ready = 1;
    tick();
    dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = 32'hFFFFFFFF;
    tick();
    dmem_rsp_valid = 0;
    check("bs_resp_stall", 32'(stall_at_memory), 32'd0);
    check("bs_resp_regwrite", 32'(wb_regWrite), 32'd0);
    check("bs_resp_load", wb_loadData, 32'd0);
    clear_inputs();
    tick();

    // byte load 0x102
    in_memRead = 1; in_word = 0; in_regWrite = 1; in_memToReg = 1; in_rd = 3;
    in_result = 32'h102; dmem_req_ready = 1;
    tick();
    check("bl_req_be", 32'(dmem_req_be), 32'h4);
    tick();
    dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h11FF2233;
    tick();
    dmem_rsp_valid = 0;
    check("bl_resp_load", wb_loadData, 32'h000000FF);
    check("bl_resp_regwrite", 32'(wb_regWrite), 32'd1);
    check("bl_resp_rd", 32'(wb_rd), 32'd3);
    clear_inputs();
    tick();

    // misaligned word load 0x102
    in_memRead = 1; in_word = 1; in_regWrite = 1; in_rd = 9; in_result = 32'h102;
`ifdef MEM_MISALIGN_EXC_EN
    #1 check("mis_stall", 32'(stall_at_memory), 32'd0);
    tick();
    check("mis_req_valid", 32'(dmem_req_valid), 32'd0);
    check("mis_exception", 32'(wb_exception), 32'd1);
    check("mis_faulty", wb_faulty_address, 32'h102);
    check("mis_regwrite", 32'(wb_regWrite), 32'd0);
    clear_inputs();
`else
    #1 check("mis_stall", 32'(stall_at_memory), 32'd1);
    tick();
    check("mis_req_valid", 32'(dmem_req_valid), 32'd1);
    check("mis_req_addr", dmem_req_addr, 32'h100);
    check("mis_req_be", 32'(dmem_req_be), 32'hF);
    dmem_req_ready = 1;
    tick();
    dmem_req_ready = 0; dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h12345678;
    tick();
    dmem_rsp_valid = 0;
    check("mis_resp_load", wb_loadData, 32'h12345678);
    clear_inputs();
`endif
    tick();

    // upstream exception: no request, pass-through with regWrite suppressed
    in_exception = 1; in_memRead = 1; in_regWrite = 1; in_rd = 4;
    in_faulty_address = 32'hBAD0; in_pc = 32'h88;
    #1 check("exc_stall", 32'(stall_at_memory), 32'd0);
    tick();
    check("exc_req_valid", 32'(dmem_req_valid), 32'd0);
    check("exc_wb_exception", 32'(wb_exception), 32'd1);
    check("exc_wb_faulty", wb_faulty_address, 32'hBAD0);
    check("exc_wb_pc", wb_pc, 32'h88);
    check("exc_wb_regwrite", 32'(wb_regWrite), 32'd0);
    clear_inputs();
    tick();

    // reset while waiting for a response; the late response must be ignored
    in_memRead = 1; in_word = 1; in_regWrite = 1; in_rd = 2; in_result = 32'h200;
    dmem_req_ready = 1;
    tick();
    tick();
    dmem_req_ready = 0;
    check("rw_wait_stall", 32'(stall_at_memory), 32'd1);
    reset_n = 0;
    clear_inputs();
    tick();
    check("rw_rst_valid", 32'(dmem_req_valid), 32'd0);
    check("rw_rst_stall", 32'(stall_at_memory), 32'd0);
    reset_n = 1; dmem_rsp_valid = 1; dmem_rsp_rdata = 32'h55;
    tick();
    dmem_rsp_valid = 0;
    check("rw_late_load", wb_loadData, 32'd0);
    check("rw_late_regwrite", 32'(wb_regWrite), 32'd0);
    check("rw_late_stall", 32'(stall_at_memory), 32'd0);
    tick();
    check("rw_idle_load", wb_loadData, 32'd0);
    check("rw_idle_valid", 32'(dmem_req_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
